serial_frame_tx: RTL

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_tx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 2-bit port, length field, then payload.
// Payload goes out LSB first; port and length go out MSB first.
module serial_frame_tx #(
  parameter int LEN_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clkEn,
  input  logic                    start,
  input  logic [1:0]              port,
  input  logic [LEN_W-1:0]        len,
  input  logic [(1<<LEN_W)-1:0]   dataIn,
  output logic                    serOut,
  output logic                    ready,
  output logic                    done
);

  localparam int DW = 1 << LEN_W;
  localparam int CW = (LEN_W > 2) ? LEN_W : 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_PORT  = 3'd2;
  localparam logic [2:0] S_LEN   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_dec, cnt_inc, len_ext;
  logic [1:0]       port_q, port_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DW-1:0]    data_q, data_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;
  logic             len_bit, data_bit;

  // cnt_q is the index of the bit currently on the line
  assign cnt_dec  = cnt_q - CW'(1);
  assign cnt_inc  = cnt_q + CW'(1);
  assign len_ext  = CW'(len_q);
  assign len_bit  = |(len_q & (LEN_W'(1) << cnt_dec));
  assign data_bit = |(data_q & (DW'(1) << cnt_inc));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    len_d   = len_q;
    data_d  = data_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    if (clkEn) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            port_d  = port;
            len_d   = len;
            data_d  = dataIn;
            ser_d   = 1'b0;
            state_d = S_START;
          end
        end
        S_START: begin
          ser_d   = port_q[1];
          cnt_d   = CW'(1);
          state_d = S_PORT;
        end
        S_PORT: begin
          if (cnt_q != '0) begin
            ser_d = port_q[0];
            cnt_d = cnt_dec;
          end else begin
            ser_d   = len_q[LEN_W-1];
            cnt_d   = CW'(LEN_W-1);
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (cnt_q != '0) begin
            ser_d = len_bit;
            cnt_d = cnt_dec;
          end else if (len_q != '0) begin
            ser_d   = data_q[0];
            cnt_d   = '0;
            state_d = S_DATA;
          end else begin
            ser_d   = 1'b1;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          if (cnt_inc == len_ext) begin
            ser_d   = 1'b1;
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ser_d = data_bit;
            cnt_d = cnt_inc;
          end
        end
        default: begin
          ser_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      port_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  assign serOut = ser_q;
  assign done   = done_q;
  assign ready  = (state_q == S_IDLE);

endmodule
